// File: rtl/avalon_pio_debounce.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pio_debounce
// Purpose  : Avalon-MM input PIO with per-channel 2-FF sync, debounce, edge
//            capture and maskable level interrupt.
// Option   : define AVALON_PIO_DEBOUNCE_IRQ_EN to build IRQ_MASK,
//            EDGE_CAPTURE and irq; otherwise irq is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_pio_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int EDGE_MODE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] debounced
);

    localparam int            c_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]   r_s1;
    logic [WIDTH-1:0]   r_s2;
    logic [WIDTH-1:0]   r_stable;
    logic [c_CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0]   w_upd;
    logic [WIDTH-1:0]   w_evt;
    logic [31:0]        w_rd_val;
    logic               w_unused_bits;

    // Inputs idle high (pull-ups), so the synchroniser resets to ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
        end
    end

    always_comb begin
        w_upd = '0;
        w_evt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_upd[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == c_CNT_MAX);
            if (EDGE_MODE == 2)
                w_evt[i] = w_upd[i];
            else if (EDGE_MODE == 0)
                w_evt[i] = w_upd[i] && r_s2[i];
            else
                w_evt[i] = w_upd[i] && !r_s2[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= '1;
            r_cnt    <= '{default: '0};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_s2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_upd[i]) begin
                    r_stable[i] <= r_s2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_W'(1);
                end
            end
        end
    end

    assign debounced = r_stable;

`ifdef AVALON_PIO_DEBOUNCE_IRQ_EN
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic             w_wr;
    logic [WIDTH-1:0] w_clr;

    assign w_wr  = chipselect && write;
    assign w_clr = (w_wr && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

    // A new event outranks a same-cycle W1C clear of that bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
            r_cap  <= '0;
        end else begin
            if (w_wr && (address == 2'd2))
                r_mask <= writedata[WIDTH-1:0];
            r_cap <= (r_cap & ~w_clr) | w_evt;
        end
    end

    assign irq = |(r_cap & r_mask);
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rd_val = '0;
        case (address)
            2'd0:    w_rd_val = 32'(r_stable);
            2'd1:    w_rd_val = 32'(r_s2);
`ifdef AVALON_PIO_DEBOUNCE_IRQ_EN
            2'd2:    w_rd_val = 32'(r_mask);
            2'd3:    w_rd_val = 32'(r_cap);
`endif
            default: w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= (chipselect && read) ? w_rd_val : '0;
    end

    // Write data and events are only partly consumed in some builds.
    assign w_unused_bits = ^{write, writedata, w_evt};

endmodule
`default_nettype wire

// File: tb/tb_avalon_pio_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_pio_debounce
// Purpose  : self-checking bench; window-based reference model, two DUTs
//            (falling-edge and both-edge capture) on shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_pio_debounce;

    localparam int W = 4;
    localparam int D = 4;
`ifdef AVALON_PIO_DEBOUNCE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] rd1, rd2;
    logic        irq1, irq2;
    logic [W-1:0] deb1, deb2;

    int n_checks = 0;
    int n_err    = 0;

    avalon_pio_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(rd1),
        .irq(irq1), .in_port(in_port), .debounced(deb1)
    );

    avalon_pio_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(rd2),
        .irq(irq2), .in_port(in_port), .debounced(deb2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the last D synchronised
    // samples of a channel all agree on a value differing from the current one.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_stable, m_mask, m_s2, m_upd, m_clr;
    logic [W-1:0] m_cap [2];
    logic [31:0]  m_rd  [2];
    bit           m_same;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist.delete();
            for (int j = 0; j < D + 2; j++) hist.push_back('1);
            m_stable = '1;
            m_mask   = '0;
            m_cap[0] = '0;
            m_cap[1] = '0;
            m_rd[0]  = '0;
            m_rd[1]  = '0;
        end else begin
            hist.push_front(in_port);
            void'(hist.pop_back());
            m_s2 = hist[2];
            for (int k = 0; k < 2; k++) begin
                m_rd[k] = '0;
                if (chipselect && read) begin
                    case (address)
                        2'd0: m_rd[k] = 32'(m_stable);
                        2'd1: m_rd[k] = 32'(m_s2);
                        2'd2: m_rd[k] = IRQ_EN ? 32'(m_mask)   : 32'h0;
                        2'd3: m_rd[k] = IRQ_EN ? 32'(m_cap[k]) : 32'h0;
                        default: m_rd[k] = '0;
                    endcase
                end
            end
            m_upd = '0;
            for (int b = 0; b < W; b++) begin
                m_same = 1'b1;
                for (int j = 3; j <= D + 1; j++)
                    if (hist[j][b] != hist[2][b]) m_same = 1'b0;
                if (m_same && (hist[2][b] != m_stable[b])) m_upd[b] = 1'b1;
            end
            m_clr    = (chipselect && write && address == 2'd3) ? writedata[W-1:0] : '0;
            m_cap[0] = (m_cap[0] & ~m_clr) | (m_upd & ~m_s2);
            m_cap[1] = (m_cap[1] & ~m_clr) | m_upd;
            if (chipselect && write && address == 2'd2) m_mask = writedata[W-1:0];
            m_stable = m_stable ^ m_upd;
        end
    end

    always @(negedge clk) begin
        check("debounced_fall", 32'(deb1), 32'(m_stable));
        check("debounced_both", 32'(deb2), 32'(m_stable));
        check("readdata_fall",  rd1, m_rd[0]);
        check("readdata_both",  rd2, m_rd[1]);
        check("irq_fall", 32'(irq1), IRQ_EN ? 32'(|(m_cap[0] & m_mask)) : 32'h0);
        check("irq_both", 32'(irq2), IRQ_EN ? 32'(|(m_cap[1] & m_mask)) : 32'h0);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        step();
        chipselect = 1'b0; write = 1'b0; writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a; chipselect = 1'b1; read = 1'b1;
        step();
        chipselect = 1'b0; read = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; read = 1'b0;
        write = 1'b0; writedata = '0; in_port = 4'hF;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Reset state
        check("rst_deb", 32'(deb1), 32'hF);
        check("rst_irq", 32'(irq1), 32'h0);
        check("rst_rd",  rd1, 32'h0);
        bus_read(2'd0); check("rst_data", rd1, 32'hF);
        bus_read(2'd1); check("rst_raw",  rd1, 32'hF);
        bus_read(2'd2); check("rst_mask", rd1, 32'h0);
        bus_read(2'd3); check("rst_cap",  rd1, 32'h0);
        step();         check("idle_rd",  rd1, 32'h0);

        // Clean press on ch0
        bus_write(2'd2, 32'h1);
        in_port = 4'hE;
        repeat (5) step();
        check("press_before_e6", 32'(deb1), 32'hF);
        step();
        check("press_at_e6", 32'(deb1), 32'hE);
        check("press_irq", 32'(irq1), IRQ_EN ? 32'h1 : 32'h0);
        bus_read(2'd3); check("press_cap",  rd1, IRQ_EN ? 32'h1 : 32'h0);
        bus_read(2'd0); check("press_data", rd1, 32'hE);
        bus_write(2'd3, 32'h1);
        check("press_clr_irq", 32'(irq1), 32'h0);

        // Bounce: 3 low, 1 high, then steady low
        in_port = 4'hF;
        repeat (8) step();
        bus_write(2'd3, 32'hF);
        in_port = 4'hE; repeat (3) step();
        in_port = 4'hF; step();
        check("bounce_nochange", 32'(deb1), 32'hF);
        in_port = 4'hE;
        repeat (5) step();
        check("bounce_before", 32'(deb1), 32'hF);
        step();
        check("bounce_fall", 32'(deb1), 32'hE);
        check("bounce_irq", 32'(irq1), IRQ_EN ? 32'h1 : 32'h0);

        // W1C colliding with a new falling edge
        in_port = 4'hF;
        repeat (8) step();
        bus_write(2'd3, 32'hF);
        check("coll_pre_irq", 32'(irq1), 32'h0);
        in_port = 4'hE;
        repeat (5) step();
        bus_write(2'd3, 32'h1);
        check("coll_irq_kept", 32'(irq1), IRQ_EN ? 32'h1 : 32'h0);
        bus_read(2'd3); check("coll_cap", rd1, IRQ_EN ? 32'h1 : 32'h0);
        bus_write(2'd3, 32'h1);
        check("coll_cleared_irq", 32'(irq1), 32'h0);

        // Simultaneous release ch1 / press ch2
        in_port = 4'hC;
        repeat (8) step();
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'h0);
        in_port = 4'hA;
        repeat (6) step();
        check("multi_deb", 32'(deb2), 32'hA);
        check("multi_irq_masked", 32'(irq2), 32'h0);
        bus_read(2'd3);
        check("multi_cap_both", rd2, IRQ_EN ? 32'h6 : 32'h0);
        check("multi_cap_fall", rd1, IRQ_EN ? 32'h4 : 32'h0);
        bus_write(2'd2, 32'h4);
        check("multi_irq_both", 32'(irq2), IRQ_EN ? 32'h1 : 32'h0);
        check("multi_irq_fall", 32'(irq1), IRQ_EN ? 32'h1 : 32'h0);

        // Asynchronous reset in the middle of a count
        in_port = 4'hF;
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        check("mid_rst_deb", 32'(deb1), 32'hF);
        check("mid_rst_irq", 32'(irq2), 32'h0);
        check("mid_rst_rd",  rd1, 32'h0);
        step();
        reset_n = 1'b1;
        repeat (6) step();
        check("post_rst_deb", 32'(deb1), 32'hF);
        bus_read(2'd0); check("post_rst_data", rd1, 32'hF);
        bus_read(2'd1); check("post_rst_raw",  rd1, 32'hF);
        bus_read(2'd2); check("post_rst_mask", rd1, 32'h0);
        bus_read(2'd3); check("post_rst_cap",  rd2, 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avalon_pio_debounce.md
# avalon_pio_debounce

Parametrised Avalon-MM input PIO with per-channel synchronisation, debouncing, edge capture and maskable interrupt. It sits between board push-buttons/slide switches (KEY, SW, SMA_IN, IR) and the Nios II system interconnect. It replaces the plain input PIOs: one instance per input group, sized by `WIDTH`.

## Interface
Parameters:
- `WIDTH`, 4: number of input channels, 1..32.
- `DEBOUNCE_CYCLES`, 250000: consecutive cycles a new level must persist before it is accepted, >=1. 250000 is 5 ms at 50 MHz.
- `EDGE_MODE`, 1: edge that sets the capture bit. 0 = rising, 1 = falling, 2 = both.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register word address.
- `chipselect`  in  1  slave select.
- `read`  in  1  read strobe.
- `write`  in  1  write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `irq`  out  1  level interrupt, active high.
- `in_port`  in  WIDTH  asynchronous board inputs.
- `debounced`  out  WIDTH  debounced levels, for fabric use.

## Operation
- **Synchroniser:** a 2-FF synchroniser (`s1`, `s2`) is applied per channel. Both stages reset to all ones, because the inputs are pull-up, active-low.
- **Per-channel debounce counter:**
  - Width is `$clog2(DEBOUNCE_CYCLES)`, minimum 1.
  - `s2 == stable`: the counter clears to 0.
  - `s2 != stable` and count < DEBOUNCE_CYCLES-1: the counter increments.
  - `s2 != stable` and count == DEBOUNCE_CYCLES-1: `stable` takes `s2` and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes `stable`.
- **Stable level:** `stable` resets to all ones. `debounced` equals `stable`.
- **Edge event:** asserted on the cycle `stable` updates, with direction checked against `EDGE_MODE`.
  - The event sets the channel's `edge_capture` bit.
  - If a W1C clear and a set hit the same bit on the same cycle, the set wins.
- **Interrupt:** `irq = |(edge_capture & irq_mask)`. It is combinational from registers and holds until software clears the capture bit or the mask bit.
- **Register map:** word addresses; bits above `WIDTH` read 0.
  - 0 DATA, RO: `stable`.
  - 1 RAW, RO: `s2`.
  - 2 IRQ_MASK, RW: reset value 0.
  - 3 EDGE_CAPTURE, R/W1C: reset value 0. Writing 1 clears the bit; writing 0 has no effect.
- **Bus rules:**
  - Writes to RO registers are ignored.
  - `read` and `write` asserted together: the write is performed and `readdata` returns the pre-write value.

## Timing
- **Reset values:** `readdata` = 0, `irq` = 0, `debounced` = all ones. All counters, mask and capture reset to 0.
- **Read latency:** fixed at 1 cycle, no waitrequest.
  - `readdata` is updated on the edge where `chipselect & read` is sampled, and is valid the following cycle.
  - Otherwise `readdata` returns 0.
- **Write:** takes effect on the edge where `chipselect & write` is sampled.
- **Input latency:** `in_port` changes before edge 1. `s1` updates at edge 1 and `s2` at edge 2. `stable`, `debounced` and `edge_capture` update at edge DEBOUNCE_CYCLES+2. `irq` follows immediately after that edge.
- **Bounce:** a bounce back to `stable` clears the count. A new full run of DEBOUNCE_CYCLES mismatched cycles is then required.
- **Reset mid-operation:** asynchronous assertion clears all state immediately. In-flight counts are discarded.
- **Independence:** channels are fully independent, and simultaneous edges on several channels all capture on the same cycle.

## Configuration
- **Macro:** `AVALON_PIO_DEBOUNCE_IRQ_EN`.
- **Defined:** IRQ_MASK, EDGE_CAPTURE, edge detection and `irq` are implemented as above.
- **Undefined:**
  - Addresses 2 and 3 read 0 and writes to them are ignored.
  - `irq` is tied 0 and no capture or mask flops are built.
  - DATA, RAW, debounce and `debounced` are unchanged.

## Test plan
All scenarios use WIDTH=4, DEBOUNCE_CYCLES=4 and EDGE_MODE=1 unless stated.
1. **Reset:** assert `reset_n`=0 mid-count.
   - `debounced` returns to 4'hF, `irq` to 0, and all registers read 0 except DATA = 0xF and RAW = 0xF.
2. **Clean press:** drive `in_port` 4'hF->4'hE before edge 1.
   - `debounced[0]` falls at edge 6.
   - With IRQ_MASK = 0x1, `EDGE_CAPTURE` = 0x1 and `irq` goes high after edge 6.
   - A read of addr 0 returns 0xE one cycle later.
3. **Bounce:** toggle `in_port[0]` low for 3 cycles, high for 1, then low steady.
   - There is no change before the steady run, and `debounced[0]` falls 6 edges after the final low.
4. **W1C collision:** write 0x1 to addr 3 on the same cycle as a new falling edge on ch0.
   - Bit 0 stays 1 and `irq` stays high.
   - A later write of 0x1 with no event clears it, and `irq` falls next cycle.
5. **Edge modes and multiple channels:** with EDGE_MODE=2, release ch1 and press ch2 together.
   - `EDGE_CAPTURE` = 0x6 on the same cycle.
   - With IRQ_MASK = 0x0, `irq` stays 0; writing IRQ_MASK = 0x4 raises `irq`.
6. **Macro undefined:** repeat scenario 2.
   - DATA behaves identically, address 3 reads 0, and `irq` stays 0 throughout.
